usb_capture_packer: RTL and testbench
=====================================

Name: usb_capture_packer

Overview:
- Sits between the ULPI wrapper's UTMI receive outputs and the sniffer's memory/host path.
- Frames each received USB packet as a timestamped record: one header word followed by packed data words.
- Buffers records in an internal FIFO, parametrised in word width and depth.
- Only complete packets become visible downstream. On overflow the whole packet is dropped, counted, and flagged in the next record.

Parameters:
- DATA_W, 32: output/storage word width; 32 or 64; bytes per word BPW = DATA_W/8.
- DEPTH, 512: FIFO depth in words; power of 2, minimum 16.
- TS_W, 16: timestamp counter width; at most 16.

Ports:
- clk_i  in  1  60MHz ULPI clock.
- rst_i  in  1  reset.
- enable_i  in  1  capture enable; sampled only in IDLE.
- utmi_rxvalid_i  in  1  data byte valid.
- utmi_rxactive_i  in  1  packet in progress.
- utmi_rxerror_i  in  1  receive error.
- utmi_data_i  in  8  received byte.
- utmi_linestate_i  in  2  line state.
- out_valid_o  out  1  output word valid.
- out_data_o  out  DATA_W  output word.
- out_last_o  out  1  last word of a record.
- out_ready_i  in  1  downstream accept.
- level_o  out  $clog2(DEPTH)+1  committed words held.
- drop_count_o  out  16  dropped packets, saturating at 0xFFFF.
- busy_o  out  1  FSM not in IDLE.

Behaviour:
- Clock and reset:
  - Single clock domain clk_i.
  - Reset rst_i is synchronous and active-high.
  - All outputs are 0 at reset. Pointers, timestamp, drop flag and counters clear.
- Timestamp: free-running TS_W-bit counter; wraps silently.
- Header word (low 32 bits; upper bits 0 when DATA_W=64):
  - [31:30] type: 00 = packet, 01 = linestate.
  - [29] rxerror seen.
  - [28] drops occurred since the previous record.
  - [27:16] byte length (packet) or 0.
  - [15:0] timestamp, zero-extended.
  - Linestate record only: [1:0] new linestate, replacing timestamp bits [1:0]; the remaining timestamp bits are kept.
- Data packing: byte i goes to word i/BPW, lane i%BPW (LSB first). The final word is zero-padded.
- FIFO storage: DATA_W+1 bits per entry; the extra bit is last.
- Pointers:
  - wr_spec: speculative write pointer.
  - commit: visible write pointer.
  - rd: read pointer.
  - Used-space check is wr_spec - rd, modulo 2*DEPTH.
- FSM states:
  - IDLE
    - On a utmi_rxactive_i rising edge with enable_i=1: latch timestamp, reserve the header slot at wr_spec (needs ≥1 free slot, else go to DROP), wr_spec+1, go to RX.
  - RX
    - Each rxvalid byte goes into the pack register.
    - When the register is full, write it at wr_spec and advance. If no free slot: roll back wr_spec to commit and go to DROP.
    - rxerror sets the err flag.
    - Length saturates at 4095; further bytes are discarded and err is set.
    - On rxactive falling:
      - length 0: roll back, go to IDLE, no record.
      - otherwise: flush the partial word (needs a slot, else DROP), mark last, go to COMMIT.
  - COMMIT: write the header into the reserved slot; commit = wr_spec; clear the drop flag; go to IDLE. Takes 1 cycle.
  - DROP: drop_count+1 (saturating), set the drop flag, wait for rxactive low, go to IDLE.
- Output path:
  - Show-ahead with registered RAM read.
  - A word committed in cycle N gives out_valid_o in cycle N+2 at the earliest.
  - out_data_o and out_last_o are held stable while valid and not ready.
  - rd advances only on valid && ready.
  - Sustained throughput is 1 word per cycle.
- level_o = commit - rd.
- Simultaneous commit and read in one cycle are both honoured.
- Reset during RX: no partial record is ever emitted.

Optional Feature:
- USB_CAPTURE_LINESTATE_EN defined:
  - In IDLE, a linestate differing from the last recorded value emits a one-word type-01 record with last=1.
  - It needs 1 free slot, else it counts as a drop.
  - A change during a packet is recorded after the packet's COMMIT.
  - If a packet start and a linestate change occur in the same cycle, the packet wins.
- Not defined: linestate is ignored and type 01 is never produced.

Decomposition:
- Package usb_capture_pkg:
  - Record type constants.
  - Header field bit positions.
  - MAX_LEN = 4095.
  - FSM state enum.
- Sub-module usb_capture_ram: simple dual-port, sync read, DEPTH x (DATA_W+1).

Test Plan:
- DATA_W=32; bytes C3,01,02 starting at ts 0x0010 -> words 0x0003_0010 (last=0), then 0x0002_01C3 (last=1); level_o 2 then 0 after reads.
- DATA_W=64; 9-byte packet 00..08 -> header, 0x0706050403020100, 0x0000000000000008 (last=1).
- DEPTH=16, out_ready_i=0:
  - Two 40-byte packets -> first committed (level 11); second dropped, drop_count_o=1, level stays 11.
  - Next packet's header has bit28=1.
- rxerror pulse mid-packet -> header bit29=1; data intact.
- rst_i asserted mid-RX for 1 cycle -> all outputs 0; next packet's record is correct; nothing partial emitted.
- With USB_CAPTURE_LINESTATE_EN: linestate 01 -> 10 in IDLE -> one word, 0x4000_xxx2 with last=1.

Source files
------------

// File: rtl/usb_capture_pkg.sv
// Shared types and constants for the USB capture packer.
// Record type codes, header field positions, length limit, FSM states.
package usb_capture_pkg;

  localparam logic [1:0] REC_PKT = 2'b00;
  localparam logic [1:0] REC_LS  = 2'b01;

  localparam int TYPE_LO  = 30;
  localparam int ERR_BIT  = 29;
  localparam int DROP_BIT = 28;
  localparam int LEN_LO   = 16;
  localparam int TS_LO    = 0;

  localparam logic [11:0] MAX_LEN = 12'd4095;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RX,
    ST_COMMIT,
    ST_DROP
  } state_t;

  function automatic logic [31:0] make_hdr(
    input logic [1:0]  typ,
    input logic        err,
    input logic        drop,
    input logic [11:0] len,
    input logic [15:0] ts
  );
    logic [31:0] h;
    h = '0;
    h[TYPE_LO +: 2] = typ;
    h[ERR_BIT]      = err;
    h[DROP_BIT]     = drop;
    h[LEN_LO +: 12] = len;
    h[TS_LO +: 16]  = ts;
    return h;
  endfunction

endpackage

// File: rtl/usb_capture_ram.sv
// Simple dual-port RAM, one write port, one registered read port.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (sync read).
module usb_capture_ram #(
  parameter int DEPTH = 512,
  parameter int W     = 33
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/usb_capture_packer.sv
// Frames UTMI receive packets into timestamped header+data records in a
// FIFO; only complete packets become visible, overflowing packets drop.
// Ports: clk_i, rst_i (sync, active-high), enable_i, utmi_* receive side,
// out_valid_o/out_data_o/out_last_o/out_ready_i record stream,
// level_o (committed words), drop_count_o, busy_o.
// Optional: define USB_CAPTURE_LINESTATE_EN to emit linestate records.
module usb_capture_packer
  import usb_capture_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512,
  parameter int TS_W   = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic                     utmi_rxvalid_i,
  input  logic                     utmi_rxactive_i,
  input  logic                     utmi_rxerror_i,
  input  logic [7:0]               utmi_data_i,
  input  logic [1:0]               utmi_linestate_i,
  output logic                     out_valid_o,
  output logic [DATA_W-1:0]        out_data_o,
  output logic                     out_last_o,
  input  logic                     out_ready_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [15:0]              drop_count_o,
  output logic                     busy_o
);

  localparam int BPW = DATA_W / 8;
  localparam int LW  = $clog2(BPW);
  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = AW + 1;

  state_t state, state_nxt;

  logic [TS_W-1:0]   ts, ts_lat, ts_lat_nxt;
  logic              rxact_q;
  logic [PW-1:0]     wr_spec, wr_spec_nxt;
  logic [PW-1:0]     commit, commit_nxt;
  logic [PW-1:0]     rd, rd_nxt;
  logic [PW-1:0]     hdr_ptr, hdr_ptr_nxt;
  logic [PW-1:0]     wr_prev, used;
  logic [LW-1:0]     lane, lane_nxt;
  logic [DATA_W-1:0] pack, pack_nxt, pack_base;
  logic [DATA_W-1:0] hdr_word;
  logic [11:0]       len, len_nxt;
  logic              err, err_nxt;
  logic              drop_flag, drop_flag_nxt;
  logic [15:0]       drop_cnt, drop_cnt_nxt;
  logic              has_free, start, go_drop;
  logic              we;
  logic [AW-1:0]     waddr;
  logic [DATA_W:0]   wdata;
  logic [DATA_W:0]   q;
  logic              avail, pop;

`ifdef USB_CAPTURE_LINESTATE_EN
  logic [1:0]        ls_last, ls_last_nxt;
  logic [15:0]       ts16;
  logic [DATA_W-1:0] ls_word;
`else
  logic              unused_ls;
  assign unused_ls = ^utmi_linestate_i;
`endif

  assign used     = wr_spec - rd;
  assign has_free = used < PW'(DEPTH);
  assign wr_prev  = wr_spec - PW'(1);
  assign start    = enable_i && utmi_rxactive_i && !rxact_q;
  assign pop      = avail && out_ready_i;
  assign rd_nxt   = rd + PW'(pop);

  always_comb begin
    hdr_word = '0;
    hdr_word[31:0] = make_hdr(REC_PKT, err, drop_flag, len, 16'(ts_lat));
  end

`ifdef USB_CAPTURE_LINESTATE_EN
  always_comb begin
    ts16 = 16'(ts);
    ls_word = '0;
    ls_word[31:0] = make_hdr(REC_LS, 1'b0, drop_flag, 12'd0,
                             {ts16[15:2], utmi_linestate_i});
  end
`endif

  always_comb begin
    state_nxt     = state;
    wr_spec_nxt   = wr_spec;
    commit_nxt    = commit;
    hdr_ptr_nxt   = hdr_ptr;
    lane_nxt      = lane;
    pack_nxt      = pack;
    len_nxt       = len;
    err_nxt       = err;
    drop_flag_nxt = drop_flag;
    drop_cnt_nxt  = drop_cnt;
    ts_lat_nxt    = ts_lat;
    go_drop       = 1'b0;
    we            = 1'b0;
    waddr         = wr_spec[AW-1:0];
    wdata         = '0;
    // A full word stays in pack after it is written so the final
    // word can be rewritten with last set; a new word starts clean.
    pack_base     = (lane == '0) ? '0 : pack;
`ifdef USB_CAPTURE_LINESTATE_EN
    ls_last_nxt   = ls_last;
`endif
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          ts_lat_nxt = ts;
          len_nxt    = '0;
          lane_nxt   = '0;
          err_nxt    = 1'b0;
          pack_nxt   = '0;
          if (has_free) begin
            hdr_ptr_nxt = wr_spec;
            wr_spec_nxt = wr_spec + PW'(1);
            state_nxt   = ST_RX;
          end else begin
            go_drop   = 1'b1;
            state_nxt = ST_DROP;
          end
        end
`ifdef USB_CAPTURE_LINESTATE_EN
        // Only track the idle line; toggling during packets is data.
        else if (enable_i && !utmi_rxactive_i &&
                 utmi_linestate_i != ls_last) begin
          ls_last_nxt = utmi_linestate_i;
          if (has_free) begin
            we            = 1'b1;
            wdata         = {1'b1, ls_word};
            wr_spec_nxt   = wr_spec + PW'(1);
            commit_nxt    = wr_spec + PW'(1);
            drop_flag_nxt = 1'b0;
          end else begin
            go_drop = 1'b1;
          end
        end
`endif
      end
      ST_RX: begin
        if (utmi_rxerror_i) err_nxt = 1'b1;
        if (!utmi_rxactive_i) begin
          if (len == '0) begin
            wr_spec_nxt = commit;
            state_nxt   = ST_IDLE;
          end else if (lane == '0) begin
            we        = 1'b1;
            waddr     = wr_prev[AW-1:0];
            wdata     = {1'b1, pack};
            state_nxt = ST_COMMIT;
          end else if (has_free) begin
            we          = 1'b1;
            wdata       = {1'b1, pack};
            wr_spec_nxt = wr_spec + PW'(1);
            state_nxt   = ST_COMMIT;
          end else begin
            go_drop   = 1'b1;
            state_nxt = ST_DROP;
          end
        end else if (utmi_rxvalid_i) begin
          if (len == MAX_LEN) begin
            err_nxt = 1'b1;
          end else begin
            pack_nxt = pack_base;
            pack_nxt[int'(lane)*8 +: 8] = utmi_data_i;
            len_nxt  = len + 12'd1;
            lane_nxt = lane + LW'(1);
            if (lane == LW'(BPW-1)) begin
              if (has_free) begin
                we          = 1'b1;
                wdata       = {1'b0, pack_nxt};
                wr_spec_nxt = wr_spec + PW'(1);
              end else begin
                go_drop   = 1'b1;
                state_nxt = ST_DROP;
              end
            end
          end
        end
      end
      ST_COMMIT: begin
        we            = 1'b1;
        waddr         = hdr_ptr[AW-1:0];
        wdata         = {1'b0, hdr_word};
        commit_nxt    = wr_spec;
        drop_flag_nxt = 1'b0;
        state_nxt     = ST_IDLE;
      end
      ST_DROP: begin
        if (!utmi_rxactive_i) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (go_drop) begin
      wr_spec_nxt   = commit;
      drop_flag_nxt = 1'b1;
      if (drop_cnt != 16'hFFFF) drop_cnt_nxt = drop_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      ts        <= '0;
      ts_lat    <= '0;
      // Treat the line as already active so a packet in flight at
      // reset release is never captured from its middle.
      rxact_q   <= 1'b1;
      wr_spec   <= '0;
      commit    <= '0;
      rd        <= '0;
      hdr_ptr   <= '0;
      lane      <= '0;
      pack      <= '0;
      len       <= '0;
      err       <= 1'b0;
      drop_flag <= 1'b0;
      drop_cnt  <= '0;
      avail     <= 1'b0;
`ifdef USB_CAPTURE_LINESTATE_EN
      ls_last   <= '0;
`endif
    end else begin
      state     <= state_nxt;
      ts        <= ts + TS_W'(1);
      ts_lat    <= ts_lat_nxt;
      rxact_q   <= utmi_rxactive_i;
      wr_spec   <= wr_spec_nxt;
      commit    <= commit_nxt;
      rd        <= rd_nxt;
      hdr_ptr   <= hdr_ptr_nxt;
      lane      <= lane_nxt;
      pack      <= pack_nxt;
      len       <= len_nxt;
      err       <= err_nxt;
      drop_flag <= drop_flag_nxt;
      drop_cnt  <= drop_cnt_nxt;
      // RAM output this cycle holds mem[rd_nxt]; valid if committed.
      avail     <= (commit != rd_nxt);
`ifdef USB_CAPTURE_LINESTATE_EN
      ls_last   <= ls_last_nxt;
`endif
    end
  end

  usb_capture_ram #(
    .DEPTH (DEPTH),
    .W     (DATA_W + 1)
  ) u_ram (
    .clk   (clk_i),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (rd_nxt[AW-1:0]),
    .rdata (q)
  );

  assign out_valid_o  = avail;
  assign out_data_o   = avail ? q[DATA_W-1:0] : '0;
  assign out_last_o   = avail & q[DATA_W];
  assign level_o      = commit - rd;
  assign drop_count_o = drop_cnt;
  assign busy_o       = (state != ST_IDLE);

endmodule

// File: tb/tb_usb_capture_packer.sv
// Directed bench for usb_capture_packer: 32-bit and 64-bit instances,
// both DEPTH=16, driven from one shared UTMI stimulus.
module tb_usb_capture_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       en32 = 1'b0, en64 = 1'b0;
  logic       rxvalid = 1'b0, rxactive = 1'b0, rxerror = 1'b0;
  logic [7:0] data = '0;
  logic [1:0] ls = 2'b00;

  logic        v32, l32, b32, rdy32 = 1'b0;
  logic [31:0] d32;
  logic [4:0]  lvl32;
  logic [15:0] dc32;

  logic        v64, l64, b64, rdy64 = 1'b0;
  logic [63:0] d64;
  logic [4:0]  lvl64;
  logic [15:0] dc64;

  int checks = 0;
  int failures = 0;
  logic [7:0] pkt[$];

  usb_capture_packer #(.DATA_W(32), .DEPTH(16), .TS_W(16)) u32 (
    .clk_i(clk), .rst_i(rst), .enable_i(en32),
    .utmi_rxvalid_i(rxvalid), .utmi_rxactive_i(rxactive),
    .utmi_rxerror_i(rxerror), .utmi_data_i(data),
    .utmi_linestate_i(ls),
    .out_valid_o(v32), .out_data_o(d32), .out_last_o(l32),
    .out_ready_i(rdy32), .level_o(lvl32),
    .drop_count_o(dc32), .busy_o(b32)
  );

  usb_capture_packer #(.DATA_W(64), .DEPTH(16), .TS_W(16)) u64 (
    .clk_i(clk), .rst_i(rst), .enable_i(en64),
    .utmi_rxvalid_i(rxvalid), .utmi_rxactive_i(rxactive),
    .utmi_rxerror_i(rxerror), .utmi_data_i(data),
    .utmi_linestate_i(ls),
    .out_valid_o(v64), .out_data_o(d64), .out_last_o(l64),
    .out_ready_i(rdy64), .level_o(lvl64),
    .drop_count_o(dc64), .busy_o(b64)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_pkt(input int err_idx);
    rxactive = 1'b1;
    tick();
    foreach (pkt[i]) begin
      rxvalid = 1'b1;
      data    = pkt[i];
      rxerror = (i == err_idx);
      tick();
    end
    rxvalid  = 1'b0;
    rxerror  = 1'b0;
    data     = '0;
    rxactive = 1'b0;
    repeat (3) tick();
  endtask

  task automatic pop32(input string tag, input logic [31:0] exp,
                       input logic [31:0] mask, input logic exp_last);
    chk({tag, "_valid"}, 64'(v32), 64'd1);
    chk({tag, "_data"}, 64'(d32 & mask), 64'(exp));
    chk({tag, "_last"}, 64'(l32), 64'(exp_last));
    rdy32 = 1'b1;
    tick();
    rdy32 = 1'b0;
  endtask

  task automatic pop64(input string tag, input logic [63:0] exp,
                       input logic [63:0] mask, input logic exp_last);
    chk({tag, "_valid"}, 64'(v64), 64'd1);
    chk({tag, "_data"}, d64 & mask, exp);
    chk({tag, "_last"}, 64'(l64), 64'(exp_last));
    rdy64 = 1'b1;
    tick();
    rdy64 = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    en32 = 1'b1;

    // reset state, then 16 free-running cycles -> ts 0x0010
    do_reset(0);
    chk("rst_valid", 64'(v32), 64'd0);
    chk("rst_data", 64'(d32), 64'd0);
    chk("rst_last", 64'(l32), 64'd0);
    chk("rst_level", 64'(lvl32), 64'd0);
    chk("rst_drops", 64'(dc32), 64'd0);
    chk("rst_busy", 64'(b32), 64'd0);
    repeat (16) tick();

    // three-byte packet, partial final word
    pkt = {8'hC3, 8'h01, 8'h02};
    send_pkt(-1);
    chk("t1_level", 64'(lvl32), 64'd2);
    chk("t1_hdr", 64'(d32), 64'h0003_0010);
    tick();
    chk("t1_hold", 64'(d32), 64'h0003_0010);
    pop32("t1_w0", 32'h0003_0010, 32'hFFFF_FFFF, 1'b0);
    pop32("t1_w1", 32'h0002_01C3, 32'hFFFF_FFFF, 1'b1);
    chk("t1_empty_valid", 64'(v32), 64'd0);
    chk("t1_empty_level", 64'(lvl32), 64'd0);

    // rxerror pulse on byte 1
    pkt = {8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    send_pkt(1);
    chk("t2_level", 64'(lvl32), 64'd3);
    pop32("t2_hdr", 32'h2005_0000, 32'hFFFF_0000, 1'b0);
    pop32("t2_w0", 32'hA4A3_A2A1, 32'hFFFF_FFFF, 1'b0);
    pop32("t2_w1", 32'h0000_00A5, 32'hFFFF_FFFF, 1'b1);

    // overflow: 40 bytes fit (11 words), second 40 bytes drop
    pkt = {};
    for (int i = 0; i < 40; i++) pkt.push_back(8'(i));
    send_pkt(-1);
    chk("t3_level_a", 64'(lvl32), 64'd11);
    chk("t3_drops_a", 64'(dc32), 64'd0);
    pkt = {};
    for (int i = 0; i < 40; i++) pkt.push_back(8'(100 + i));
    send_pkt(-1);
    chk("t3_level_b", 64'(lvl32), 64'd11);
    chk("t3_drops_b", 64'(dc32), 64'd1);
    pop32("t3_hdr", 32'h0028_0000, 32'hFFFF_0000, 1'b0);
    for (int k = 0; k < 10; k++) begin
      w = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
      pop32($sformatf("t3_w%0d", k), w, 32'hFFFF_FFFF, k == 9);
    end
    chk("t3_drained", 64'(lvl32), 64'd0);
    pkt = {8'h55};
    send_pkt(-1);
    pop32("t3_flag_hdr", 32'h1001_0000, 32'hFFFF_0000, 1'b0);
    pop32("t3_flag_w0", 32'h0000_0055, 32'hFFFF_FFFF, 1'b1);

    // reset for one cycle in the middle of a packet
    rxactive = 1'b1;
    tick();
    chk("t4_busy", 64'(b32), 64'd1);
    rxvalid = 1'b1;
    data = 8'h11;
    tick();
    data = 8'h22;
    tick();
    data = 8'h33;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_valid", 64'(v32), 64'd0);
    chk("t4_data", 64'(d32), 64'd0);
    chk("t4_level", 64'(lvl32), 64'd0);
    chk("t4_drops", 64'(dc32), 64'd0);
    chk("t4_busy0", 64'(b32), 64'd0);
    data = 8'h44;
    tick();
    rxvalid = 1'b0;
    rxactive = 1'b0;
    repeat (3) tick();
    chk("t4_nopartial_lvl", 64'(lvl32), 64'd0);
    chk("t4_nopartial_vld", 64'(v32), 64'd0);
    // ts is 4 here: reset edge left 0, four cycles since
    pkt = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_pkt(-1);
    chk("t4_level2", 64'(lvl32), 64'd2);
    pop32("t4_hdr", 32'h0004_0004, 32'hFFFF_FFFF, 1'b0);
    pop32("t4_w0", 32'hEFBE_ADDE, 32'hFFFF_FFFF, 1'b1);

    // 64-bit instance: nine bytes
    en32 = 1'b0;
    en64 = 1'b1;
    pkt = {};
    for (int i = 0; i < 9; i++) pkt.push_back(8'(i));
    send_pkt(-1);
    chk("t5_level", 64'(lvl64), 64'd3);
    chk("t5_other_idle", 64'(lvl32), 64'd0);
    pop64("t5_hdr", 64'h0000_0000_0009_0000,
          64'hFFFF_FFFF_FFFF_0000, 1'b0);
    pop64("t5_w0", 64'h0706_0504_0302_0100, '1, 1'b0);
    pop64("t5_w1", 64'h0000_0000_0000_0008, '1, 1'b1);
    chk("t5_empty", 64'(lvl64), 64'd0);

    // linestate changes while idle
    en64 = 1'b0;
    en32 = 1'b1;
    ls = 2'b01;
    repeat (3) tick();
`ifdef USB_CAPTURE_LINESTATE_EN
    chk("t6_level_a", 64'(lvl32), 64'd1);
    pop32("t6_ls01", 32'h4000_0001, 32'hFFFF_0003, 1'b1);
    ls = 2'b10;
    repeat (3) tick();
    chk("t6_level_b", 64'(lvl32), 64'd1);
    pop32("t6_ls10", 32'h4000_0002, 32'hFFFF_0003, 1'b1);
`else
    chk("t6_level_a", 64'(lvl32), 64'd0);
    ls = 2'b10;
    repeat (3) tick();
    chk("t6_level_b", 64'(lvl32), 64'd0);
    chk("t6_valid", 64'(v32), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
